bsg_spmd_reset_sequencer: RTL and testbench



---
 rtl/bsg_spmd_reset_sequencer.sv | 174 +++++++++++++++++
 tb/tb_bsg_spmd_reset_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_spmd_reset_sequencer.sv
// bsg_spmd_reset_sequencer
//   Releases manycore core reset once tag-chain programming has been stable
//   for reset_hold_cycles_p cycles, then releases the host I/O reset after a
//   further io_release_delay_p cycles. While running it counts cycles and
//   print-stat events, and latches the host finish.
//   Optional watchdog: define BSG_SPMD_RESET_SEQ_WATCHDOG_EN to add a TIMEOUT
//   state entered when the run-cycle count hits watchdog_cycles_p without a
//   finish; otherwise timeout_o is constant 0.
module bsg_spmd_reset_sequencer #(
   parameter int reset_hold_cycles_p = 3,
   parameter int io_release_delay_p  = 2,
   parameter int ctr_width_p         = 32,
   parameter int data_width_p        = 32,
   parameter int watchdog_cycles_p   = 1000000
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    tag_done_i,
   input  logic                    print_stat_v_i,
   input  logic [data_width_p-1:0] print_stat_tag_i,
   input  logic                    finish_v_i,
   output logic                    core_reset_o,
   output logic                    io_reset_o,
   output logic [ctr_width_p-1:0]  run_cycles_o,
   output logic [ctr_width_p-1:0]  stat_count_o,
   output logic [data_width_p-1:0] last_stat_tag_o,
   output logic                    done_o,
   output logic                    timeout_o
);

   // One counter serves both the hold phase and the I/O delay phase.
   localparam int cnt_max_lp = (reset_hold_cycles_p > io_release_delay_p)
                               ? reset_hold_cycles_p : io_release_delay_p;
   localparam int cnt_w_lp   = $clog2(cnt_max_lp + 1) + 1;

   localparam logic [2:0] wait_tag_s = 3'd0;
   localparam logic [2:0] hold_s     = 3'd1;
   localparam logic [2:0] io_dly_s   = 3'd2;
   localparam logic [2:0] run_s      = 3'd3;
   localparam logic [2:0] done_s     = 3'd4;
`ifdef BSG_SPMD_RESET_SEQ_WATCHDOG_EN
   localparam logic [2:0] timeout_s  = 3'd5;
`endif

   localparam logic [cnt_w_lp-1:0] hold_last_lp = cnt_w_lp'(reset_hold_cycles_p);
   localparam logic [cnt_w_lp-1:0] dly_last_lp  = cnt_w_lp'(io_release_delay_p);
   localparam logic [ctr_width_p-1:0] ctr_max_lp = '1;

   logic [2:0]              state_q, state_d;
   logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
   logic                    core_reset_q, core_reset_d;
   logic                    io_reset_q, io_reset_d;
   logic [ctr_width_p-1:0]  run_cycles_q, run_cycles_d;
   logic [ctr_width_p-1:0]  stat_count_q, stat_count_d;
   logic [data_width_p-1:0] last_stat_tag_q, last_stat_tag_d;
   logic                    done_q, done_d;
   logic                    timeout_q, timeout_d;

   // Next-state and next-output computation for the release sequence.
   always_comb begin
      // NOTE: every signal gets a hold-value default first so no path leaves it unassigned (no latches).
      state_d         = state_q;
      cnt_d           = cnt_q;
      core_reset_d    = core_reset_q;
      io_reset_d      = io_reset_q;
      run_cycles_d    = run_cycles_q;
      stat_count_d    = stat_count_q;
      last_stat_tag_d = last_stat_tag_q;
      done_d          = done_q;
      timeout_d       = timeout_q;

      // Losing tag_done before RUN completes restarts the whole sequence;
      // stat history survives, run-cycle count does not.
      if (!tag_done_i && (state_q == hold_s || state_q == io_dly_s || state_q == run_s)) begin
         state_d      = wait_tag_s;
         cnt_d        = '0;
         core_reset_d = 1'b1;
         io_reset_d   = 1'b1;
         run_cycles_d = '0;
      end else begin
         case (state_q)
            wait_tag_s: begin
               if (tag_done_i) begin
                  state_d = hold_s;
                  cnt_d   = cnt_w_lp'(1);
               end
            end
            hold_s: begin
               if (cnt_q == hold_last_lp) begin
                  core_reset_d = 1'b0;
                  if (io_release_delay_p == 0) begin
                     io_reset_d = 1'b0;
                     state_d    = run_s;
                     cnt_d      = '0;
                  end else begin
                     state_d = io_dly_s;
                     cnt_d   = cnt_w_lp'(1);
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            io_dly_s: begin
               if (cnt_q == dly_last_lp) begin
                  io_reset_d = 1'b0;
                  state_d    = run_s;
                  cnt_d      = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            run_s: begin
               if (run_cycles_q != ctr_max_lp) run_cycles_d = run_cycles_q + 1'b1;
               if (print_stat_v_i) begin
                  if (stat_count_q != ctr_max_lp) stat_count_d = stat_count_q + 1'b1;
                  last_stat_tag_d = print_stat_tag_i;
               end
               if (finish_v_i) begin
                  state_d = done_s;
                  done_d  = 1'b1;
               end
`ifdef BSG_SPMD_RESET_SEQ_WATCHDOG_EN
               else if (run_cycles_q == ctr_width_p'(watchdog_cycles_p - 1)) begin
                  state_d      = timeout_s;
                  timeout_d    = 1'b1;
                  core_reset_d = 1'b1;
                  io_reset_d   = 1'b1;
               end
`endif
            end
            default: ; // DONE / TIMEOUT: frozen until reset_i
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      if (reset_i) begin
         state_q         <= wait_tag_s;
         cnt_q           <= '0;
         core_reset_q    <= 1'b1;
         io_reset_q      <= 1'b1;
         run_cycles_q    <= '0;
         stat_count_q    <= '0;
         last_stat_tag_q <= '0;
         done_q          <= 1'b0;
         timeout_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         core_reset_q    <= core_reset_d;
         io_reset_q      <= io_reset_d;
         run_cycles_q    <= run_cycles_d;
         stat_count_q    <= stat_count_d;
         last_stat_tag_q <= last_stat_tag_d;
         done_q          <= done_d;
         timeout_q       <= timeout_d;
      end
   end

   assign core_reset_o    = core_reset_q;
   assign io_reset_o      = io_reset_q;
   assign run_cycles_o    = run_cycles_q;
   assign stat_count_o    = stat_count_q;
   assign last_stat_tag_o = last_stat_tag_q;
   assign done_o          = done_q;
`ifdef BSG_SPMD_RESET_SEQ_WATCHDOG_EN
   assign timeout_o       = timeout_q;
`else
   assign timeout_o       = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_spmd_reset_sequencer.sv
// Testbench for bsg_spmd_reset_sequencer: two instances (default I/O delay
// and zero I/O delay) driven with shared stimulus and compared every cycle
// against a streak-counting reference model, plus directed checks.
module tb_bsg_spmd_reset_sequencer;

   localparam int H = 3;
   localparam int D = 2;
`ifdef BSG_SPMD_RESET_SEQ_WATCHDOG_EN
   localparam int W = 50;
`else
   localparam int W = 1000000;
`endif

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        tag_done_i = 1'b0;
   logic        print_stat_v_i = 1'b0;
   logic [31:0] print_stat_tag_i = '0;
   logic        finish_v_i = 1'b0;

   logic        core_a, io_a, done_a, to_a;
   logic [31:0] run_a, stat_a, tag_a;
   logic        core_b, io_b, done_b, to_b;
   logic [31:0] run_b, stat_b, tag_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bsg_spmd_reset_sequencer #(
      .reset_hold_cycles_p(H), .io_release_delay_p(D), .ctr_width_p(32),
      .data_width_p(32), .watchdog_cycles_p(W)
   ) dut_a (
      .clk_i(clk), .reset_i(reset_i), .tag_done_i(tag_done_i),
      .print_stat_v_i(print_stat_v_i), .print_stat_tag_i(print_stat_tag_i),
      .finish_v_i(finish_v_i), .core_reset_o(core_a), .io_reset_o(io_a),
      .run_cycles_o(run_a), .stat_count_o(stat_a), .last_stat_tag_o(tag_a),
      .done_o(done_a), .timeout_o(to_a)
   );

   bsg_spmd_reset_sequencer #(
      .reset_hold_cycles_p(H), .io_release_delay_p(0), .ctr_width_p(32),
      .data_width_p(32), .watchdog_cycles_p(W)
   ) dut_b (
      .clk_i(clk), .reset_i(reset_i), .tag_done_i(tag_done_i),
      .print_stat_v_i(print_stat_v_i), .print_stat_tag_i(print_stat_tag_i),
      .finish_v_i(finish_v_i), .core_reset_o(core_b), .io_reset_o(io_b),
      .run_cycles_o(run_b), .stat_count_o(stat_b), .last_stat_tag_o(tag_b),
      .done_o(done_b), .timeout_o(to_b)
   );

   // Reference model: k counts consecutive edges that sampled tag_done high
   // since the last restart. Core reset is off once k reaches H+1, I/O reset
   // once k reaches H+1+delay; activity counts only once I/O reset is off.
   typedef struct {
      int          k;
      logic [31:0] run;
      logic [31:0] stat;
      logic [31:0] tag;
      bit          done;
      bit          to;
   } mdl_t;

   mdl_t m_a, m_b;

   function automatic mdl_t mdl_step(mdl_t m, int dly);
      mdl_t n = m;
      logic [31:0] run_old = m.run;
      if (reset_i) begin
         n.k = 0; n.run = 0; n.stat = 0; n.tag = 0; n.done = 0; n.to = 0;
      end else if (m.done || m.to) begin
         n = m;
      end else if (!tag_done_i) begin
         n.k = 0; n.run = 0;
      end else begin
         if (m.k >= H + 1 + dly) begin
            if (run_old != 32'hFFFF_FFFF) n.run = run_old + 1;
            if (print_stat_v_i) begin
               if (m.stat != 32'hFFFF_FFFF) n.stat = m.stat + 1;
               n.tag = print_stat_tag_i;
            end
            if (finish_v_i) n.done = 1;
`ifdef BSG_SPMD_RESET_SEQ_WATCHDOG_EN
            else if (run_old == 32'(W - 1)) n.to = 1;
`endif
         end else begin
            n.k = m.k + 1;
         end
      end
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic cmp_all(input string p, input mdl_t m, input int dly,
                          input logic core, input logic io, input logic [31:0] run,
                          input logic [31:0] stat, input logic [31:0] tag,
                          input logic done, input logic to);
      check({p, ".core_reset"}, 32'(core), 32'(m.to || m.k < H + 1));
      check({p, ".io_reset"},   32'(io),   32'(m.to || m.k < H + 1 + dly));
      check({p, ".run_cycles"}, run,  m.run);
      check({p, ".stat_count"}, stat, m.stat);
      check({p, ".last_tag"},   tag,  m.tag);
      check({p, ".done"},       32'(done), 32'(m.done));
      check({p, ".timeout"},    32'(to),   32'(m.to));
   endtask

   // One clock: inputs already applied are sampled at the edge; outputs are
   // compared 1 time unit later.
   task automatic tick();
      @(posedge clk);
      m_a = mdl_step(m_a, D);
      m_b = mdl_step(m_b, 0);
      #1;
      cmp_all("a", m_a, D, core_a, io_a, run_a, stat_a, tag_a, done_a, to_a);
      cmp_all("b", m_b, 0, core_b, io_b, run_b, stat_b, tag_b, done_b, to_b);
   endtask

   task automatic do_reset();
      reset_i = 1; tag_done_i = 0; print_stat_v_i = 0; finish_v_i = 0;
      tick(); tick();
      reset_i = 0;
   endtask

   // Hold tag_done high and record the edge number (1 = first edge sampling
   // it high) at which each reset falls. Bounded to 20 edges.
   task automatic release_seq(output int ca, output int ia, output int cb, output int ib);
      ca = -1; ia = -1; cb = -1; ib = -1;
      tag_done_i = 1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (ca < 0 && !core_a) ca = n;
         if (ia < 0 && !io_a)   ia = n;
         if (cb < 0 && !core_b) cb = n;
         if (ib < 0 && !io_b)   ib = n;
         if (ia > 0 && ib > 0) break;
      end
   endtask

   initial begin
      int ca, ia, cb, ib;
      logic [31:0] frozen;
      bit glitch_ok;
      m_a = '{default: 0};
      m_b = '{default: 0};

      // Reset state
      do_reset();
      check("rst.core", 32'(core_a), 32'd1);
      check("rst.io",   32'(io_a),   32'd1);
      check("rst.run",  run_a, 32'd0);

      // Release timing, both instances
      release_seq(ca, ia, cb, ib);
      check("seq.core_edge",  ca, H + 1);
      check("seq.io_edge",    ia, H + 1 + D);
      check("seq.run_first",  run_a, 32'd0);
      check("seq0.core_edge", cb, H + 1);
      check("seq0.io_edge",   ib, H + 1);

      // Stats then finish coincident with a sixth stat
      for (int i = 0; i < 5; i++) begin
         print_stat_v_i = 1; print_stat_tag_i = 32'h10 + i; tick();
         print_stat_v_i = 0; tick();
      end
      print_stat_v_i = 1; print_stat_tag_i = 32'h15; finish_v_i = 1; tick();
      print_stat_v_i = 0; finish_v_i = 0;
      check("fin.stat", stat_a, 32'd6);
      check("fin.tag",  tag_a,  32'h15);
      check("fin.done", 32'(done_a), 32'd1);
      frozen = run_a;
      for (int i = 0; i < 5; i++) begin
         print_stat_v_i = 1; finish_v_i = 1; tag_done_i = (i != 2); tick();
      end
      print_stat_v_i = 0; finish_v_i = 0; tag_done_i = 1;
      check("fin.run_frozen", run_a, frozen);
      check("fin.stat_frozen", stat_a, 32'd6);

      // Tag glitch: high 2 edges, low 1, then high again
      do_reset();
      tag_done_i = 1; tick(); tick();
      tag_done_i = 0; tick();
      glitch_ok = core_a && io_a;
      check("glitch.core_held", 32'(glitch_ok), 32'd1);
      release_seq(ca, ia, cb, ib);
      check("glitch.core_edge", ca, H + 1);

      // reset_i in RUN after 100 cycles
      for (int i = 0; i < 100; i++) begin
         print_stat_v_i = ($urandom_range(0, 3) == 0);
         print_stat_tag_i = $urandom;
         tick();
      end
      print_stat_v_i = 0;
      reset_i = 1; tick();
      check("midrst.core", 32'(core_a), 32'd1);
      check("midrst.io",   32'(io_a),   32'd1);
      check("midrst.run",  run_a,  32'd0);
      check("midrst.stat", stat_a, 32'd0);
      check("midrst.tag",  tag_a,  32'd0);
      reset_i = 0; tag_done_i = 0; tick();

`ifdef BSG_SPMD_RESET_SEQ_WATCHDOG_EN
      // Watchdog: no finish
      do_reset();
      release_seq(ca, ia, cb, ib);
      for (int i = 0; i < W + 5; i++) tick();
      check("wd.timeout", 32'(to_a), 32'd1);
      check("wd.core",    32'(core_a), 32'd1);
      check("wd.io",      32'(io_a), 32'd1);
      // Watchdog: finish in the limit cycle wins
      do_reset();
      release_seq(ca, ia, cb, ib);
      for (int i = 0; i < 200 && run_a != 32'(W - 1); i++) tick();
      finish_v_i = 1; tick(); finish_v_i = 0;
      for (int i = 0; i < 5; i++) tick();
      check("wdfin.done",    32'(done_a), 32'd1);
      check("wdfin.timeout", 32'(to_a), 32'd0);
`endif

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         reset_i          = ($urandom_range(0, 599) == 0);
         tag_done_i       = ($urandom_range(0, 49) != 0);
         print_stat_v_i   = ($urandom_range(0, 3) == 0);
         print_stat_tag_i = $urandom;
         finish_v_i       = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
